muldiv_seq: RTL and testbench

Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the MIPS core. It has no arithmetic unit of its own: while busy it takes ownership of the shared 32-bit ALU and drives its A/B/op inputs, one step per cycle (shift-add multiply, restoring divide). It holds the architectural HI/LO registers and commits results only on successful completion. It sits beside the EX stage; the top level muxes the ALU inputs from this block when `alu_own` is high and stalls the pipeline on `busy`.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_step.sv | 99 +++++++++
 rtl/muldiv_seq.sv | 141 ++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: ALU op codes driven onto the shared ALU, op encodings, FSM state enum.
package muldiv_pkg;

  localparam logic [3:0] ALU_ADDU = 4'b1011;
  localparam logic [3:0] ALU_SUBU = 4'b1100;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_LOOP   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5
  } state_e;

  // op[0] clear means a signed op (MULT, DIV); op[1] set means a divide.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Per-cycle ALU drive and next-value logic for the acc/mq/opnd working registers.
// Latency: purely combinational; alu_c comes back from the shared ALU in the same cycle.
// Backpressure: none; the caller decides whether the next values are loaded.
//
// Ports: i_state/i_is_div/i_sa/i_sb/i_lz select the step; i_acc/i_mq/i_opnd are the
// working registers; i_alu_c is the ALU result; o_alu_* drive the ALU; o_*_nxt are
// the values to load on the next edge.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  state_e           i_state,
  input  logic             i_is_div,
  input  logic             i_sa,
  input  logic             i_sb,
  input  logic             i_lz,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mq,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_alu_c,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_op,
  output logic [WIDTH-1:0] o_acc_nxt,
  output logic [WIDTH-1:0] o_mq_nxt,
  output logic [WIDTH-1:0] o_opnd_nxt,
  output logic             o_lz_nxt
);

  logic [WIDTH-1:0] w_s;      // divide: remainder shifted left with next dividend bit
  logic             w_ge;     // divide: trial subtraction fits
  logic             w_carry;  // multiply: carry out of the 32-bit add
  logic             w_neg;    // multiply/quotient result must be negated

  // The remainder is really 33 bits wide; acc[31] is the bit shifted out of s.
  // If it is set, s+2^32 >= opnd always holds and alu_c is the correct low word.
  assign w_s     = {i_acc[WIDTH-2:0], i_mq[WIDTH-1]};
  assign w_ge    = i_acc[WIDTH-1] | ~(i_alu_c > w_s);
  assign w_carry = (i_alu_c < i_acc);
  assign w_neg   = i_sa ^ i_sb;

  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_op   = ALU_ADDU;
    o_acc_nxt  = i_acc;
    o_mq_nxt   = i_mq;
    o_opnd_nxt = i_opnd;
    o_lz_nxt   = i_lz;
    case (i_state)
      S_ABS_A: begin
        o_alu_b  = i_mq;
        o_alu_op = ALU_SUBU;
        if (i_sa) o_mq_nxt = i_alu_c;
      end
      S_ABS_B: begin
        o_alu_b  = i_opnd;
        o_alu_op = ALU_SUBU;
        if (i_sb) o_opnd_nxt = i_alu_c;
      end
      S_LOOP: begin
        if (i_is_div) begin
          o_alu_a   = w_s;
          o_alu_b   = i_opnd;
          o_alu_op  = ALU_SUBU;
          o_acc_nxt = w_ge ? i_alu_c : w_s;
          o_mq_nxt  = {i_mq[WIDTH-2:0], w_ge};
        end else begin
          o_alu_a   = i_acc;
          o_alu_b   = i_mq[0] ? i_opnd : '0;
          o_acc_nxt = {w_carry, i_alu_c[WIDTH-1:1]};
          o_mq_nxt  = {i_alu_c[0], i_mq[WIDTH-1:1]};
        end
      end
      S_FIX_LO: begin
        o_alu_b  = i_mq;
        o_alu_op = ALU_SUBU;
        o_lz_nxt = (i_mq == '0);
        if (w_neg) o_mq_nxt = i_alu_c;
      end
      S_FIX_HI: begin
        if (i_is_div) begin
          // remainder takes the sign of the dividend
          o_alu_b  = i_acc;
          o_alu_op = ALU_SUBU;
          if (i_sa) o_acc_nxt = i_alu_c;
        end else begin
          // high word of a 64-bit negate: ~hi plus the borrow from a zero low word
          o_alu_a = ~i_acc;
          o_alu_b = {{(WIDTH-1){1'b0}}, i_lz};
          if (w_neg) o_acc_nxt = i_alu_c;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer borrowing the shared ALU; owns HI/LO.
// Latency: start in cycle 0, done + new HI/LO in cycle 33 (unsigned) or 37 (signed).
// Backpressure: start is ignored while busy; cancel aborts with no commit.
//
// Ports: i_clk, i_rst (async, active high); i_start/i_op/i_rs_val/i_rt_val issue an op;
// i_cancel flushes; o_alu_a/o_alu_b/o_alu_op drive the shared ALU, i_alu_c returns its
// result; o_alu_own/o_busy high while sequencing; o_done pulses with HI/LO on o_hi/o_lo.
// Build option MULDIV_MTHILO_EN adds i_we_hi/i_we_lo/i_wdata for MTHI/MTLO writes.
// WIDTH must stay 32: the shared ALU interface is fixed at that width.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_cancel,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_c,
`ifdef MULDIV_MTHILO_EN
  input  logic             i_we_hi,
  input  logic             i_we_lo,
  input  logic [WIDTH-1:0] i_wdata,
`endif
  output logic             o_alu_own,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_acc, r_mq, r_opnd, r_hi, r_lo;
  logic             r_sgn, r_div, r_sa, r_sb, r_lz, r_done;

  logic [WIDTH-1:0] w_acc_nxt, w_mq_nxt, w_opnd_nxt;
  logic             w_lz_nxt;
  logic             w_last;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_state    (r_state),
    .i_is_div   (r_div),
    .i_sa       (r_sa),
    .i_sb       (r_sb),
    .i_lz       (r_lz),
    .i_acc      (r_acc),
    .i_mq       (r_mq),
    .i_opnd     (r_opnd),
    .i_alu_c    (i_alu_c),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .o_acc_nxt  (w_acc_nxt),
    .o_mq_nxt   (w_mq_nxt),
    .o_opnd_nxt (w_opnd_nxt),
    .o_lz_nxt   (w_lz_nxt)
  );

  // Final busy cycle: the edge that ends it commits HI/LO.
  assign w_last = (r_state == S_FIX_HI) ||
                  ((r_state == S_LOOP) && (r_cnt == 5'd31) && !r_sgn);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sgn   <= 1'b0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_lz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_MTHILO_EN
      if ((r_state == S_IDLE) && !i_start) begin
        if (i_we_hi) r_hi <= i_wdata;
        if (i_we_lo) r_lo <= i_wdata;
      end
`endif
      if (r_state == S_IDLE) begin
        // cancel beats a simultaneous start
        if (i_start && !i_cancel) begin
          r_acc   <= '0;
          r_mq    <= i_rs_val;
          r_opnd  <= i_rt_val;
          r_cnt   <= '0;
          r_lz    <= 1'b0;
          r_sgn   <= op_is_signed(i_op);
          r_div   <= op_is_div(i_op);
          r_sa    <= op_is_signed(i_op) & i_rs_val[WIDTH-1];
          r_sb    <= op_is_signed(i_op) & i_rt_val[WIDTH-1];
          r_state <= op_is_signed(i_op) ? S_ABS_A : S_LOOP;
        end
      end else if (i_cancel) begin
        r_state <= S_IDLE;
      end else begin
        r_acc  <= w_acc_nxt;
        r_mq   <= w_mq_nxt;
        r_opnd <= w_opnd_nxt;
        r_lz   <= w_lz_nxt;
        if (w_last) begin
          r_state <= S_IDLE;
          r_hi    <= w_acc_nxt;
          r_lo    <= w_mq_nxt;
          r_done  <= 1'b1;
        end else begin
          case (r_state)
            S_ABS_A:  r_state <= S_ABS_B;
            S_ABS_B:  r_state <= S_LOOP;
            S_LOOP: begin
              r_cnt <= r_cnt + 5'd1;
              if (r_cnt == 5'd31) r_state <= S_FIX_LO;
            end
            S_FIX_LO: r_state <= S_FIX_HI;
            default:  r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_alu_own = o_busy;
  assign o_done    = r_done;
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural shared ALU and an expected-result queue.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] alu_a, alu_b, alu_c, hi, lo;
  logic [3:0]  alu_op;
  logic        alu_own, busy, done;
`ifdef MULDIV_MTHILO_EN
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic [31:0] wdata = '0;
`endif

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // Shared ALU stand-in
  assign alu_c = (alu_op == ALU_ADDU) ? alu_a + alu_b :
                 (alu_op == ALU_SUBU) ? alu_a - alu_b : 32'h0;

  muldiv_seq #(.WIDTH(32)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op      (op),
    .i_cancel  (cancel),
    .i_rs_val  (rs),
    .i_rt_val  (rt),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_op  (alu_op),
    .i_alu_c   (alu_c),
`ifdef MULDIV_MTHILO_EN
    .i_we_hi   (we_hi),
    .i_we_lo   (we_lo),
    .i_wdata   (wdata),
`endif
    .o_alu_own (alu_own),
    .o_busy    (busy),
    .o_done    (done),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference result {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (o)
      OP_MULT:  r = longint'($signed(a)) * longint'($signed(b));
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Drive start for one cycle (cycle 0); returns at the sample point of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; check done cycle, busy cycles seen, and committed HI/LO.
  task automatic wait_done(input string tag, input int exp_cyc, input int cyc0);
    int cyc;
    int nbusy;
    logic [63:0] e;
    cyc = cyc0;
    nbusy = 0;
    while (done !== 1'b1 && cyc < exp_cyc + 20) begin
      if (busy === 1'b1 && alu_own === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk({tag, ".done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(exp_cyc - cyc0));
    chk({tag, ".hilo"}, {hi, lo}, e);
    chk({tag, ".idle_at_done"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int exp_cyc);
    exp_q.push_back(exp);
    issue(o, a, b);
    wait_done(tag, exp_cyc, 1);
  endtask

  initial begin
    int ndone;
    int nbusy;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    // Reset state
    @(negedge clk);
    chk("reset.ctrl", {57'h0, busy, done, alu_own, alu_op}, {57'h0, 3'b000, 4'b1011});
    chk("reset.hilo", {hi, lo}, 64'h0);
    chk("reset.alu", {alu_a, alu_b}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Main function; each op starts in the previous op's done cycle
    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 37);
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 37);
    run("divu", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33);
    run("divu_zero", OP_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 33);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = (i % 3 == 0) ? OP_MULTU : (i % 3 == 1) ? OP_MULT : OP_DIVU;
      if (ro == OP_DIVU && i == 5) rb = rb >> 20;
      if (rb == 0) rb = 32'd1;
      run($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), (ro == OP_MULT) ? 37 : 33);
    end

    // Preload HI/LO = 1234/5678, then cancel in the done cycle has no effect
    run("setup", OP_DIVU, 32'h5678_1234, 32'h0001_0000, 64'h0000_1234_0000_5678, 33);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_in_done", {hi, lo}, 64'h0000_1234_0000_5678);

    // Cancel in cycle 10 with a stray start in cycle 5
    issue(OP_MULTU, 32'd5, 32'd6);
    ndone = 0;
    nbusy = 0;
    for (int k = 1; k <= 10; k++) begin
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
      start = (k == 5);
      if (k == 5) begin op = OP_DIVU; rs = 32'd9; rt = 32'd3; end
      cancel = (k == 10);
      @(negedge clk);
    end
    start = 1'b0;
    cancel = 1'b0;
    chk("cancel.busy_1_10", 64'(nbusy), 64'd10);
    chk("cancel.no_done", {62'h0, done, 1'b0} | 64'(ndone), 64'h0);
    chk("cancel.busy_11", {63'h0, busy}, 64'h0);
    chk("cancel.hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    run("after_cancel", OP_MULTU, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 33);

    // cancel and start together in IDLE: not accepted
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; rs = 32'd2; rt = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start.busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    chk("cancel_start.hilo", {62'h0, busy, done}, 64'h0);

`ifdef MULDIV_MTHILO_EN
    we_hi = 1'b1; wdata = 32'hCAFE_BABE;
    @(negedge clk);
    we_hi = 1'b0;
    chk("mthi_idle", {hi, lo}, 64'hCAFE_BABE_0000_001E);
    exp_q.push_back(64'h0000_0000_0000_0006);
    issue(OP_MULTU, 32'd2, 32'd3);
    @(negedge clk);
    @(negedge clk);
    we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    we_hi = 1'b0; we_lo = 1'b0;
    chk("mthilo_busy_dropped", {hi, lo}, 64'hCAFE_BABE_0000_001E);
    wait_done("mthilo_op", 33, 4);
`endif

    // Asynchronous reset in cycle 20 of a DIV
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(negedge clk);
    chk("pre_reset.busy", {63'h0, busy}, 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset.ctrl", {57'h0, busy, done, alu_own, alu_op}, {57'h0, 3'b000, 4'b1011});
    chk("async_reset.hilo", {hi, lo}, 64'h0);
    chk("async_reset.alu", {alu_a, alu_b}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_reset", OP_MULTU, 32'd7, 32'd9, 64'h0000_0000_0000_003F, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
